// File: rtl/can_decoder.sv
// CAN frame field decoder: samples the bus once per sample_point rising edge,
// removes stuff bits from SOF through CRC, and exposes each frame field live.
module can_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_bit,
  input  logic        sample_point,
  output logic        field_start_of_frame,
  output logic [10:0] field_id_a,
  output logic        field_ide,
  output logic        field_rtr,
  output logic        field_srr,
  output logic        field_reserved1,
  output logic        field_reserved0,
  output logic [17:0] field_id_b,
  output logic [3:0]  field_dlc,
  output logic [63:0] field_data,
  output logic [14:0] field_crc,
  output logic        field_crc_delimiter,
  output logic        field_ack_slot,
  output logic        field_ack_delimiter,
  output logic        rtr_srr_temp
);

  localparam int unsigned ID_A_W = 11;
  localparam int unsigned ID_B_W = 18;
  localparam int unsigned DLC_W  = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CRC_W  = 15;
  localparam int unsigned EOF_W  = 7;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned RUN_W  = 3;

  typedef enum logic [3:0] {
    IDLE, ID_A, RTR_SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC,
    CRC_DELIM, ACK_SLOT, ACK_DELIM, EOF
  } state_t;

  state_t             state;
  logic               sp_q;
  logic               last_bit;
  logic [RUN_W-1:0]   run_len;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   data_len;

  logic               take;
  logic               destuff;
  logic               stuff_bit;
  logic [DLC_W-1:0]   dlc_next;
  logic [CNT_W-1:0]   data_len_next;

  // One sample per strobe edge; stuff handling only between SOF and the last CRC bit.
  always_comb begin
    take          = sample_point & ~sp_q;
    destuff       = state inside {ID_A, RTR_SRR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC};
    stuff_bit     = destuff && (run_len == RUN_W'(5));
    dlc_next      = {field_dlc[DLC_W-2:0], rx_bit};
    data_len_next = dlc_next[DLC_W-1] ? CNT_W'(DATA_W) : CNT_W'({dlc_next[2:0], 3'b000});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      sp_q                 <= 1'b0;
      last_bit             <= 1'b0;
      run_len              <= '0;
      bit_cnt              <= '0;
      data_len             <= '0;
      field_start_of_frame <= 1'b0;
      field_id_a           <= '0;
      field_ide            <= 1'b0;
      field_rtr            <= 1'b0;
      field_srr            <= 1'b0;
      field_reserved1      <= 1'b0;
      field_reserved0      <= 1'b0;
      field_id_b           <= '0;
      field_dlc            <= '0;
      field_data           <= '0;
      field_crc            <= '0;
      field_crc_delimiter  <= 1'b0;
      field_ack_slot       <= 1'b0;
      field_ack_delimiter  <= 1'b0;
      rtr_srr_temp         <= 1'b0;
    end else begin
      sp_q <= sample_point;
      if (take) begin
        if (stuff_bit) begin
          // A stuff bit must break the run; an equal bit aborts the frame.
          if (rx_bit == last_bit) begin
            state   <= IDLE;
            run_len <= '0;
            bit_cnt <= '0;
          end else begin
            run_len  <= RUN_W'(1);
            last_bit <= rx_bit;
          end
        end else begin
          if (destuff) begin
            run_len  <= (rx_bit == last_bit) ? run_len + RUN_W'(1) : RUN_W'(1);
            last_bit <= rx_bit;
          end
          case (state)
            IDLE: if (!rx_bit) begin
              field_start_of_frame <= rx_bit;
              field_id_a           <= '0;
              field_ide            <= 1'b0;
              field_rtr            <= 1'b0;
              field_srr            <= 1'b0;
              field_reserved1      <= 1'b0;
              field_reserved0      <= 1'b0;
              field_id_b           <= '0;
              field_dlc            <= '0;
              field_data           <= '0;
              field_crc            <= '0;
              field_crc_delimiter  <= 1'b0;
              field_ack_slot       <= 1'b0;
              field_ack_delimiter  <= 1'b0;
              rtr_srr_temp         <= 1'b0;
              run_len              <= RUN_W'(1);
              last_bit             <= 1'b0;
              bit_cnt              <= '0;
              state                <= ID_A;
            end
            ID_A: begin
              field_id_a <= {field_id_a[ID_A_W-2:0], rx_bit};
              bit_cnt    <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(ID_A_W - 1)) begin
                bit_cnt <= '0;
                state   <= RTR_SRR;
              end
            end
            RTR_SRR: begin
              rtr_srr_temp <= rx_bit;
              state        <= IDE;
            end
            IDE: begin
              field_ide <= rx_bit;
              if (rx_bit) begin
                field_srr <= rtr_srr_temp;
                state     <= ID_B;
              end else begin
                field_rtr <= rtr_srr_temp;
                state     <= R0;
              end
            end
            ID_B: begin
              field_id_b <= {field_id_b[ID_B_W-2:0], rx_bit};
              bit_cnt    <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(ID_B_W - 1)) begin
                bit_cnt <= '0;
                state   <= RTR;
              end
            end
            RTR: begin
              field_rtr <= rx_bit;
              state     <= R1;
            end
            R1: begin
              field_reserved1 <= rx_bit;
              state           <= R0;
            end
            R0: begin
              field_reserved0 <= rx_bit;
              state           <= DLC;
            end
            DLC: begin
              field_dlc <= dlc_next;
              bit_cnt   <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(DLC_W - 1)) begin
                bit_cnt  <= '0;
                data_len <= data_len_next;
                state    <= (field_rtr || dlc_next == '0) ? CRC : DATA;
              end
            end
            DATA: begin
              field_data <= {field_data[DATA_W-2:0], rx_bit};
              bit_cnt    <= bit_cnt + CNT_W'(1);
              if (bit_cnt == data_len - CNT_W'(1)) begin
                bit_cnt <= '0;
                state   <= CRC;
              end
            end
            CRC: begin
              field_crc <= {field_crc[CRC_W-2:0], rx_bit};
              bit_cnt   <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(CRC_W - 1)) begin
                bit_cnt <= '0;
                run_len <= '0;
                state   <= CRC_DELIM;
              end
            end
            CRC_DELIM: begin
              field_crc_delimiter <= rx_bit;
              state               <= ACK_SLOT;
            end
            ACK_SLOT: begin
              field_ack_slot <= rx_bit;
              state          <= ACK_DELIM;
            end
            ACK_DELIM: begin
              field_ack_delimiter <= rx_bit;
              bit_cnt             <= '0;
              state               <= EOF;
            end
            EOF: begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(EOF_W - 1)) begin
                bit_cnt <= '0;
                state   <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_decoder.sv
// Directed bench for can_decoder: builds stuffed CAN frames bit by bit and
// checks the decoded fields against hand-computed values.
module tb_can_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_bit;
  logic        sample_point;
  logic        field_start_of_frame;
  logic [10:0] field_id_a;
  logic        field_ide;
  logic        field_rtr;
  logic        field_srr;
  logic        field_reserved1;
  logic        field_reserved0;
  logic [17:0] field_id_b;
  logic [3:0]  field_dlc;
  logic [63:0] field_data;
  logic [14:0] field_crc;
  logic        field_crc_delimiter;
  logic        field_ack_slot;
  logic        field_ack_delimiter;
  logic        rtr_srr_temp;

  int vectors = 0;
  int miscompares = 0;

  logic raw[$];
  logic tx[$];

  logic [121:0] all_out;
  assign all_out = {field_start_of_frame, field_id_a, field_ide, field_rtr, field_srr,
                    field_reserved1, field_reserved0, field_id_b, field_dlc, field_data,
                    field_crc, field_crc_delimiter, field_ack_slot, field_ack_delimiter,
                    rtr_srr_temp};

  can_decoder dut (
    .clock               (clock),
    .reset               (reset),
    .rx_bit              (rx_bit),
    .sample_point        (sample_point),
    .field_start_of_frame(field_start_of_frame),
    .field_id_a          (field_id_a),
    .field_ide           (field_ide),
    .field_rtr           (field_rtr),
    .field_srr           (field_srr),
    .field_reserved1     (field_reserved1),
    .field_reserved0     (field_reserved0),
    .field_id_b          (field_id_b),
    .field_dlc           (field_dlc),
    .field_data          (field_data),
    .field_crc           (field_crc),
    .field_crc_delimiter (field_crc_delimiter),
    .field_ack_slot      (field_ack_slot),
    .field_ack_delimiter (field_ack_delimiter),
    .rtr_srr_temp        (rtr_srr_temp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_frame();
    raw.delete();
    raw.push_back(1'b0);
  endtask

  task automatic put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) raw.push_back(v[i]);
  endtask

  // Insert stuff bits from SOF through the last CRC bit, then append the unstuffed tail.
  task automatic finish_frame(input logic ack);
    int   run;
    logic last;
    tx.delete();
    run  = 0;
    last = ~raw[0];
    for (int i = 0; i < raw.size(); i++) begin
      if (run == 5) begin
        tx.push_back(~last);
        last = ~last;
        run  = 1;
      end
      tx.push_back(raw[i]);
      if (raw[i] == last) run++;
      else run = 1;
      last = raw[i];
    end
    tx.push_back(1'b1);
    tx.push_back(ack);
    tx.push_back(1'b1);
    for (int i = 0; i < 10; i++) tx.push_back(1'b1);
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    rx_bit       = b;
    sample_point = 1'b1;
    repeat (hi) @(posedge clock);
    #1;
    sample_point = 1'b0;
    repeat (lo) @(posedge clock);
    #1;
  endtask

  task automatic send_n(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) send_bit(tx[i], hi, lo);
  endtask

  task automatic build_std672();
    begin_frame();
    put(64'h672, 11);
    put(64'h0, 3);
    put(64'h8, 4);
    put(64'hAAAA_AAAA_AAAA_AAAA, 64);
    put(64'h0, 15);
    finish_frame(1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_std672(input string pfx);
    check({pfx, "_sof"},      128'(field_start_of_frame), 128'h0);
    check({pfx, "_id_a"},     128'(field_id_a),           128'h672);
    check({pfx, "_ide"},      128'(field_ide),            128'h0);
    check({pfx, "_rtr"},      128'(field_rtr),            128'h0);
    check({pfx, "_dlc"},      128'(field_dlc),            128'h8);
    check({pfx, "_data"},     128'(field_data),           128'hAAAA_AAAA_AAAA_AAAA);
    check({pfx, "_crc"},      128'(field_crc),            128'h0);
    check({pfx, "_crc_del"},  128'(field_crc_delimiter),  128'h1);
    check({pfx, "_ack_slot"}, 128'(field_ack_slot),       128'h0);
    check({pfx, "_ack_del"},  128'(field_ack_delimiter),  128'h1);
  endtask

  initial begin
    reset        = 1'b1;
    rx_bit       = 1'b1;
    sample_point = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 128'(all_out), 128'h0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Standard frame with a full 8-byte payload.
    build_std672();
    send_n(tx.size(), 1, 3);
    check_std672("std");

    // Long dominant and recessive runs force stuff bits in id, DLC/data and CRC.
    begin_frame();
    put(64'h0, 11);
    put(64'h0, 3);
    put(64'h1, 4);
    put(64'h0, 8);
    put(64'h7FFF, 15);
    finish_frame(1'b0);
    send_n(tx.size(), 1, 3);
    check("stuff_id_a", 128'(field_id_a), 128'h0);
    check("stuff_dlc",  128'(field_dlc),  128'h1);
    check("stuff_data", 128'(field_data), 128'h0);
    check("stuff_crc",  128'(field_crc),  128'h7FFF);
    check("stuff_crc_del", 128'(field_crc_delimiter), 128'h1);

    // Extended remote frame: data skipped, CRC follows DLC.
    begin_frame();
    put(64'h123, 11);
    put(64'h1, 1);
    put(64'h1, 1);
    put(64'h2ABCD, 18);
    put(64'h1, 1);
    put(64'h0, 2);
    put(64'h4, 4);
    put(64'h5A5A, 15);
    finish_frame(1'b0);
    send_n(tx.size(), 1, 3);
    check("ext_id_a", 128'(field_id_a),   128'h123);
    check("ext_temp", 128'(rtr_srr_temp), 128'h1);
    check("ext_srr",  128'(field_srr),    128'h1);
    check("ext_ide",  128'(field_ide),    128'h1);
    check("ext_id_b", 128'(field_id_b),   128'h2ABCD);
    check("ext_rtr",  128'(field_rtr),    128'h1);
    check("ext_r1",   128'(field_reserved1), 128'h0);
    check("ext_r0",   128'(field_reserved0), 128'h0);
    check("ext_dlc",  128'(field_dlc),    128'h4);
    check("ext_data", 128'(field_data),   128'h0);
    check("ext_crc",  128'(field_crc),    128'h5A5A);

    // Strobe held high for half of a 10-clock bit period.
    build_std672();
    send_n(tx.size(), 5, 5);
    check_std672("slow");

    // Decoder is idle again: a lone dominant bit is taken as SOF and clears fields.
    send_bit(1'b0, 1, 3);
    check("idle_sof_data", 128'(field_data), 128'h0);
    check("idle_sof_id_a", 128'(field_id_a), 128'h0);
    pulse_reset();
    check("reset2_outputs", 128'(all_out), 128'h0);

    // Stuff error: the bit after SOF+4 dominant bits is dominant again.
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1, 3);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1, 3);
    check("stferr_id_a", 128'(field_id_a),   128'h0);
    check("stferr_temp", 128'(rtr_srr_temp), 128'h0);
    build_std672();
    send_n(tx.size(), 1, 3);
    check_std672("after_err");

    // Reset in the middle of the payload abandons the frame.
    build_std672();
    send_n(30, 1, 3);
    check("mid_id_a", 128'(field_id_a), 128'h672);
    check("mid_dlc",  128'(field_dlc),  128'h8);
    pulse_reset();
    check("mid_reset_outputs", 128'(all_out), 128'h0);
    send_n(tx.size(), 1, 3);
    check_std672("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
